// File: rtl/cmp_seq_unit.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, signed or unsigned.
// Define CMP_EARLY_EXIT_EN to finish as soon as the first differing chunk is seen.
module cmp_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sgn,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             great,
  output logic             less,
  output logic             cond
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [2:0]       op_q, op_d;
  logic             decided_q, decided_d, gt_q, gt_d, lt_q, lt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             equal_q, equal_d, great_q, great_d, less_q, less_d, cond_q, cond_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic             ch_gt, ch_lt, res_dec, res_gt, res_lt, finish;

  function automatic logic sel_cond(input logic [2:0] o, input logic eq, input logic gt,
                                    input logic lt);
    logic c;
    case (o)
      3'd0:    c = eq;
      3'd1:    c = ~eq;
      3'd2:    c = lt;
      3'd3:    c = lt | eq;
      3'd4:    c = gt;
      3'd5:    c = gt | eq;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Signed order on the top chunk is unsigned order with the sign bit flipped.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned i = 0; i < NChunk; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (sgn_q && (idx_q == IdxW'(NChunk - 1))) begin
      a_ch[CHUNK-1] = ~a_ch[CHUNK-1];
      b_ch[CHUNK-1] = ~b_ch[CHUNK-1];
    end
  end

  assign ch_gt   = a_ch > b_ch;
  assign ch_lt   = a_ch < b_ch;
  assign res_dec = decided_q | ch_gt | ch_lt;
  assign res_gt  = decided_q ? gt_q : ch_gt;
  assign res_lt  = decided_q ? lt_q : ch_lt;

`ifdef CMP_EARLY_EXIT_EN
  assign finish = (idx_q == '0) | ch_gt | ch_lt;
`else
  assign finish = (idx_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    op_d      = op_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    equal_d   = equal_q;
    great_d   = great_q;
    less_d    = less_q;
    cond_d    = cond_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d   = StBusy;
          idx_d     = IdxW'(NChunk - 1);
          a_d       = A;
          b_d       = B;
          sgn_d     = sgn;
          op_d      = op;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end
      StBusy: begin
        decided_d = res_dec;
        gt_d      = res_gt;
        lt_d      = res_lt;
        if (finish) begin
          state_d = StDone;
          equal_d = ~res_dec;
          great_d = res_gt;
          less_d  = res_lt;
          cond_d  = sel_cond(op_q, ~res_dec, res_gt, res_lt);
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StBusy);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      op_q      <= 3'd0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      equal_q   <= 1'b0;
      great_q   <= 1'b0;
      less_q    <= 1'b0;
      cond_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      op_q      <= op_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      equal_q   <= equal_d;
      great_q   <= great_d;
      less_q    <= less_d;
      cond_q    <= cond_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign equal = equal_q;
  assign great = great_q;
  assign less  = less_q;
  assign cond  = cond_q;

endmodule

// File: tb/tb_cmp_seq_unit.sv
// Self-checking bench for cmp_seq_unit (WIDTH=32, CHUNK=8): per-cycle model compare plus
// directed scenarios with literal expectations.
module tb_cmp_seq_unit;

  localparam int NC = 4;
`ifdef CMP_EARLY_EXIT_EN
  localparam int LatTop = 2;
  localparam int LatOp6 = 3;
`else
  localparam int LatTop = 5;
  localparam int LatOp6 = 5;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        sgn_in = 1'b0;
  logic [2:0]  op_in = 3'd0;
  logic        busy, done, equal, great, less, cond;

  int checks = 0;
  int passes = 0;

  cmp_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .sgn   (sgn_in),
    .op    (op_in),
    .busy  (busy),
    .done  (done),
    .equal (equal),
    .great (great),
    .less  (less),
    .cond  (cond)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Whole-word compare: {equal, great, less, cond}.
  function automatic logic [3:0] exp_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input logic [2:0] o);
    logic eq, gt, lt, c;
    eq = (a == b);
    if (s) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    case (o)
      3'd0: c = eq;
      3'd1: c = !eq;
      3'd2: c = lt;
      3'd3: c = lt | eq;
      3'd4: c = gt;
      3'd5: c = gt | eq;
      default: c = 1'b0;
    endcase
    return {eq, gt, lt, c};
  endfunction

  // Number of busy cycles for one compare.
  function automatic int busy_cycles(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = NC;
`ifdef CMP_EARLY_EXIT_EN
    for (int j = NC - 1; j >= 0; j--) begin
      if (a[j*8 +: 8] != b[j*8 +: 8]) begin
        n = NC - j;
        break;
      end
    end
`endif
    return n;
  endfunction

  int       m_left = 0;
  logic     m_done = 1'b0;
  logic [3:0] m_flags = '0;
  logic [3:0] p_flags = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_flags <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_flags <= p_flags;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left  <= busy_cycles(a_in, b_in);
        p_flags <= exp_flags(a_in, b_in, sgn_in, op_in);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_busy", busy, (m_left > 0));
    chk("m_done", done, m_done);
    chk("m_equal", equal, m_flags[3]);
    chk("m_great", great, m_flags[2]);
    chk("m_less", less, m_flags[1]);
    chk("m_cond", cond, m_flags[0]);
  end

  // Caller is at a negedge; start is sampled at the next posedge (edge 0).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [2:0] o);
    a_in = a;
    b_in = b;
    sgn_in = s;
    op_in = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = ~a;
    b_in = a ^ 32'h5a5a_5a5a;
    sgn_in = ~s;
    op_in = ~o;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", done, 1);
  endtask

  task automatic check_res(input string tag, input int n, input int lat, input logic eq,
                           input logic gt, input logic lt, input logic cd);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_equal"}, equal, eq);
    chk({tag, "_great"}, great, gt);
    chk({tag, "_less"}, less, lt);
    chk({tag, "_cond"}, cond, cd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_equal", equal, 0);
    chk("rst_great", great, 0);
    chk("rst_less", less, 0);
    chk("rst_cond", cond, 0);
    reset = 1'b0;
    @(negedge clk);

    launch(32'h8000_0000, 32'h0000_0001, 1'b1, 3'd2);
    wait_done(1, n);
    check_res("signed_lt", n, LatTop, 0, 0, 1, 1);
    @(negedge clk);

    launch(32'h8000_0000, 32'h0000_0001, 1'b0, 3'd4);
    wait_done(1, n);
    check_res("unsigned_gt", n, LatTop, 0, 1, 0, 1);
    @(negedge clk);

    launch(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd3);
    wait_done(1, n);
    check_res("eq_le", n, 5, 1, 0, 0, 1);
    @(negedge clk);

    launch(32'h1234_5678, 32'h1234_5678, 1'b1, 3'd1);
    wait_done(1, n);
    check_res("eq_ne", n, 5, 1, 0, 0, 0);
    @(negedge clk);

    // Second start while busy must be ignored.
    launch(32'd5, 32'd7, 1'b0, 3'd2);
    @(negedge clk);
    a_in = 32'd9;
    b_in = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", busy, 1);
    wait_done(3, n);
    check_res("ignored_start", n, 5, 0, 0, 1, 1);

    // Back-to-back start in the DONE cycle.
    launch(32'd9, 32'd1, 1'b0, 3'd4);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    chk("b2b_hold_less", less, 1);
    wait_done(1, n);
    check_res("b2b", n, 5, 0, 1, 0, 1);
    @(negedge clk);

    // Reset in cycle 3 aborts and clears outputs at once.
    launch(32'hffff_0000, 32'h0000_ffff, 1'b1, 3'd2);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_equal", equal, 0);
    chk("abort_great", great, 0);
    chk("abort_less", less, 0);
    chk("abort_cond", cond, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    launch(32'hffff_0000, 32'h0000_ffff, 1'b1, 3'd2);
    wait_done(1, n);
    check_res("after_reset", n, LatTop, 0, 0, 1, 1);
    @(negedge clk);

    launch(32'h0001_0000, 32'h0002_0000, 1'b0, 3'd6);
    wait_done(1, n);
    check_res("op6", n, LatOp6, 0, 0, 1, 0);
    @(negedge clk);

    launch(32'hffff_fffe, 32'hffff_ffff, 1'b1, 3'd5);
    wait_done(1, n);
    check_res("neg_ge", n, 5, 0, 0, 1, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
